// File: rtl/rv_decode_pkg.sv
// Shared RV32I/RV64I decode constants: major opcodes and immediate format codes.
package rv_decode_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_Z    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

endpackage

// File: rtl/imm_decode_comb.sv
// Pure combinational immediate extraction: instruction word -> {imm, fmt, illegal}.
module imm_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ENABLE_CSR = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit IS_RV64 = (XLEN == 64);

    // Every sign-extended format fits in 32 bits; widen once at the end.
    logic signed [31:0] imm_s32;
    logic               zero_ext;

    always_comb begin
        imm_s32  = '0;
        zero_ext = 1'b0;
        fmt      = FMT_NONE;
        illegal  = 1'b0;
        case (instr[6:0])
            OP_IMM, LOAD, JALR: begin
                fmt     = FMT_I;
                imm_s32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_IMM_32: begin
                if (IS_RV64) begin
                    fmt     = FMT_I;
                    imm_s32 = {{20{instr[31]}}, instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            STORE: begin
                fmt     = FMT_S;
                imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            BRANCH: begin
                fmt     = FMT_B;
                imm_s32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                fmt     = FMT_U;
                imm_s32 = {instr[31:12], 12'b0};
            end
            JAL: begin
                fmt     = FMT_J;
                imm_s32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
            end
            SYSTEM: begin
                if (ENABLE_CSR != 0) begin
                    fmt      = FMT_Z;
                    zero_ext = 1'b1;
                    imm_s32  = {27'b0, instr[19:15]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OP, MISC_MEM: begin
                fmt = FMT_NONE;
            end
            OP_32: begin
                illegal = !IS_RV64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = zero_ext ? XLEN'(unsigned'(imm_s32)) : XLEN'(imm_s32);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered, valid/ready immediate generator with a main output register and
// one skid entry, so in_ready never depends combinationally on out_ready.
module imm_gen_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 32,
    parameter int ENABLE_CSR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    imm_decode_comb #(
        .XLEN       (XLEN),
        .ENABLE_CSR (ENABLE_CSR)
    ) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    logic             m_valid_reg,   m_valid_next;
    logic [XLEN-1:0]  m_imm_reg,     m_imm_next;
    logic [2:0]       m_fmt_reg,     m_fmt_next;
    logic             m_illegal_reg, m_illegal_next;
    logic [TAG_W-1:0] m_tag_reg,     m_tag_next;

    logic             k_valid_reg,   k_valid_next;
    logic [XLEN-1:0]  k_imm_reg,     k_imm_next;
    logic [2:0]       k_fmt_reg,     k_fmt_next;
    logic             k_illegal_reg, k_illegal_next;
    logic [TAG_W-1:0] k_tag_reg,     k_tag_next;

    logic in_ready_reg, in_ready_next;
    logic accept;
    logic drain;

    assign accept = in_valid & in_ready_reg;
    assign drain  = m_valid_reg & out_ready;

    always_comb begin
        m_valid_next   = m_valid_reg;
        m_imm_next     = m_imm_reg;
        m_fmt_next     = m_fmt_reg;
        m_illegal_next = m_illegal_reg;
        m_tag_next     = m_tag_reg;
        k_valid_next   = k_valid_reg;
        k_imm_next     = k_imm_reg;
        k_fmt_next     = k_fmt_reg;
        k_illegal_next = k_illegal_reg;
        k_tag_next     = k_tag_reg;

        if (drain && k_valid_reg) begin
            // in_ready is low whenever K is occupied, so no accept can collide here.
            m_imm_next     = k_imm_reg;
            m_fmt_next     = k_fmt_reg;
            m_illegal_next = k_illegal_reg;
            m_tag_next     = k_tag_reg;
            k_valid_next   = 1'b0;
        end else if (accept && (drain || !m_valid_reg)) begin
            m_valid_next   = 1'b1;
            m_imm_next     = dec_imm;
            m_fmt_next     = dec_fmt;
            m_illegal_next = dec_illegal;
            m_tag_next     = in_tag;
        end else if (accept) begin
            k_valid_next   = 1'b1;
            k_imm_next     = dec_imm;
            k_fmt_next     = dec_fmt;
            k_illegal_next = dec_illegal;
            k_tag_next     = in_tag;
        end else if (drain) begin
            m_valid_next   = 1'b0;
        end

        in_ready_next = ~k_valid_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg   <= 1'b0;
            m_imm_reg     <= '0;
            m_fmt_reg     <= FMT_NONE;
            m_illegal_reg <= 1'b0;
            m_tag_reg     <= '0;
            k_valid_reg   <= 1'b0;
            k_imm_reg     <= '0;
            k_fmt_reg     <= FMT_NONE;
            k_illegal_reg <= 1'b0;
            k_tag_reg     <= '0;
            in_ready_reg  <= 1'b0;
        end else begin
            m_valid_reg   <= m_valid_next;
            m_imm_reg     <= m_imm_next;
            m_fmt_reg     <= m_fmt_next;
            m_illegal_reg <= m_illegal_next;
            m_tag_reg     <= m_tag_next;
            k_valid_reg   <= k_valid_next;
            k_imm_reg     <= k_imm_next;
            k_fmt_reg     <= k_fmt_next;
            k_illegal_reg <= k_illegal_next;
            k_tag_reg     <= k_tag_next;
            in_ready_reg  <= in_ready_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = m_valid_reg;
    assign out_imm     = m_imm_reg;
    assign out_fmt     = m_fmt_reg;
    assign out_illegal = m_illegal_reg;
    assign out_tag     = m_tag_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: an RV32/CSR-enabled instance and an RV64/CSR-disabled instance
// share the same stimulus; expected values are hand-computed constants.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_tag;
    logic [2:0]  out_fmt;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [2:0]  out_fmt64;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ENABLE_CSR(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ENABLE_CSR(0)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One instruction through both instances with out_ready held high.
    task automatic apply(input string name, input logic [31:0] instr, input logic [31:0] tag,
                         input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic e_ill,
                         input logic [63:0] e_imm64, input logic [2:0] e_fmt64,
                         input logic e_ill64);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_tag    = tag;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_imm"}, 64'(out_imm), 64'(e_imm));
        check({name, "_fmt"}, 64'(out_fmt), 64'(e_fmt));
        check({name, "_ill"}, 64'(out_illegal), 64'(e_ill));
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
        check({name, "_imm64"}, out_imm64, e_imm64);
        check({name, "_fmt64"}, 64'(out_fmt64), 64'(e_fmt64));
        check({name, "_ill64"}, 64'(out_illegal64), 64'(e_ill64));
        $display("vector %s instr=%08h imm=%0h fmt=%0d ill=%0d imm64=%0h fmt64=%0d ill64=%0d",
                 name, instr, out_imm, out_fmt, out_illegal, out_imm64, out_fmt64,
                 out_illegal64);
    endtask

    initial begin
        int exp_tag;
        int send_tag;
        logic acc;

        // Reset state
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_fmt", 64'(out_fmt), 64'd7);
        check("rst_ill", 64'(out_illegal), 64'd0);
        check("rst_tag", 64'(out_tag), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rel_ready", 64'(in_ready), 64'd1);
        check("rel_ready64", 64'(in_ready64), 64'd1);

        // Directed decode vectors
        apply("addi", 32'hFFF00093, 32'h10, 32'hFFFFFFFF, 3'd0, 1'b0,
              64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
        apply("lui", 32'h123450B7, 32'h11, 32'h12345000, 3'd3, 1'b0,
              64'h0000000012345000, 3'd3, 1'b0);
        apply("lui_neg", 32'h800000B7, 32'h12, 32'h80000000, 3'd3, 1'b0,
              64'hFFFFFFFF80000000, 3'd3, 1'b0);
        apply("beq", 32'hFE000CE3, 32'h13, 32'hFFFFFFF8, 3'd2, 1'b0,
              64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        apply("jal", 32'hFFDFF06F, 32'h14, 32'hFFFFFFFC, 3'd4, 1'b0,
              64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
        apply("sw", 32'hFE112E23, 32'h15, 32'hFFFFFFFC, 3'd1, 1'b0,
              64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0);
        apply("csrrwi", 32'h3002D073, 32'h16, 32'h00000005, 3'd5, 1'b0,
              64'h0, 3'd7, 1'b1);
        apply("bad_op", 32'h0000007F, 32'h17, 32'h0, 3'd7, 1'b1,
              64'h0, 3'd7, 1'b1);
        apply("add", 32'h002081B3, 32'h18, 32'h0, 3'd7, 1'b0,
              64'h0, 3'd7, 1'b0);
        apply("addiw", 32'hFFF0809B, 32'h19, 32'h0, 3'd7, 1'b1,
              64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
        apply("addw", 32'h002081BB, 32'h1A, 32'h0, 3'd7, 1'b1,
              64'h0, 3'd7, 1'b0);
        step();
        check("idle_valid", 64'(out_valid), 64'd0);

        // Back-pressure: tags 1..6 with out_ready low for 3 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_tag    = 32'd1;
        check("s_rdy_start", 64'(in_ready), 64'd1);
        step();
        in_tag = 32'd2;
        check("s_hold1_tag", 64'(out_tag), 64'd1);
        check("s_rdy_one", 64'(in_ready), 64'd1);
        step();
        in_tag = 32'd3;
        check("s_rdy_full", 64'(in_ready), 64'd0);
        check("s_hold2_tag", 64'(out_tag), 64'd1);
        step();
        check("s_rdy_still", 64'(in_ready), 64'd0);
        check("s_hold3_tag", 64'(out_tag), 64'd1);
        check("s_hold3_valid", 64'(out_valid), 64'd1);
        $display("stream hold: out_tag=%0d in_ready=%0d", out_tag, in_ready);

        out_ready = 1'b1;
        exp_tag   = 1;
        send_tag  = 3;
        for (int c = 0; c < 20 && exp_tag <= 6; c++) begin
            check("s_gap", 64'(out_valid), 64'd1);
            check("s_order", 64'(out_tag), 64'(exp_tag));
            $display("stream out: tag=%0d expected=%0d", out_tag, exp_tag);
            exp_tag++;
            acc = in_valid & in_ready;
            step();
            if (acc) begin
                if (send_tag == 6) begin
                    in_valid = 1'b0;
                end else begin
                    send_tag++;
                    in_tag = 32'(send_tag);
                end
            end
        end
        check("s_count", 64'(exp_tag), 64'd7);
        check("s_drained", 64'(out_valid), 64'd0);

        // Asynchronous reset with M and K both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'h21;
        step();
        in_tag = 32'h22;
        step();
        in_valid = 1'b0;
        check("f_full_rdy", 64'(in_ready), 64'd0);
        check("f_full_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_ready", 64'(in_ready), 64'd0);
        check("ar_tag", 64'(out_tag), 64'd0);
        check("ar_fmt", 64'(out_fmt), 64'd7);
        $display("async reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("ar_rel_ready", 64'(in_ready), 64'd1);
        check("ar_rel_valid", 64'(out_valid), 64'd0);
        apply("post_rst", 32'h123450B7, 32'h77, 32'h12345000, 3'd3, 1'b0,
              64'h0000000012345000, 3'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
